// File: rtl/rvx10_pkg.sv
// Shared encodings for the RVX10 execute path: ALU op codes, branch funct3, forward selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rvx10_pkg;

  localparam int SHAMT_W = 5;

  // ALU operation codes carried on ALUControlE; codes 20..31 are undefined and yield 0.
  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_SLT  = 5'd5,
    ALU_SLTU = 5'd6,
    ALU_SLL  = 5'd7,
    ALU_SRL  = 5'd8,
    ALU_SRA  = 5'd9,
    ALU_ANDN = 5'd10,
    ALU_ORN  = 5'd11,
    ALU_XNOR = 5'd12,
    ALU_MIN  = 5'd13,
    ALU_MAX  = 5'd14,
    ALU_MINU = 5'd15,
    ALU_MAXU = 5'd16,
    ALU_ROL  = 5'd17,
    ALU_ROR  = 5'd18,
    ALU_ABS  = 5'd19
  } alu_op_e;

  // Branch conditions on Funct3E; 010 and 011 are never taken.
  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_funct3_e;

  // Operand source selects from the forwarding unit; 11 falls back to the register file.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX operand+control bundle into the execute stage and the EX/MEM register bundle out of it.
// Latency: n/a (wiring only).
// Backpressure: none on the bus itself; EnM/FlushM steer the EX/MEM register.
// Ports: slave = execute-stage view (ID/EX, forwarding, EnM/FlushM in; EX/MEM, redirect out);
//        master = the driving pipeline / bench view, directions mirrored.
interface ex_stage_if #(
  parameter int XLEN = 32
);
  // ID/EX operands and controls
  logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]      RdE;
  logic [2:0]      Funct3E;
  logic [4:0]      ALUControlE;
  logic            ALUSrcE, RegWriteE, MemWriteE, BranchE, JumpE, JalrE;
  logic [1:0]      ResultSrcE;
  // forwarding / pipeline control
  logic [1:0]      ForwardA, ForwardB;
  logic [XLEN-1:0] ResultW;
  logic            EnM, FlushM;
  // EX/MEM register outputs
  logic [XLEN-1:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]      RdM;
  logic            RegWriteM, MemWriteM;
  logic [1:0]      ResultSrcM;
  // fetch redirect
  logic [XLEN-1:0] PCTargetE;
  logic            PCSrcE;

  modport slave (
    input  RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, Funct3E, ALUControlE,
           ALUSrcE, RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ResultSrcE,
           ForwardA, ForwardB, ResultW, EnM, FlushM,
    output ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM, ResultSrcM,
           PCTargetE, PCSrcE
  );

  modport master (
    output RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, Funct3E, ALUControlE,
           ALUSrcE, RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ResultSrcE,
           ForwardA, ForwardB, ResultW, EnM, FlushM,
    input  ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM, ResultSrcM,
           PCTargetE, PCSrcE
  );
endinterface

// File: rtl/ex_stage_alu.sv
// RVX10 ALU: base RV32 integer ops plus ANDN/ORN/XNOR/MIN/MAX/MINU/MAXU/ROL/ROR/ABS.
// Latency: purely combinational.
// Backpressure: none.
// Ports: a_i/b_i operands, ctrl_i op code (rvx10_pkg::alu_op_e), y_o result (wraps mod 2^XLEN).
module alu #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [4:0]      ctrl_i,
  output logic [XLEN-1:0] y_o
);
  import rvx10_pkg::*;

  logic [SHAMT_W-1:0] shamt;
  logic               lt_s, lt_u;
  logic [XLEN-1:0]    neg_a, rol_v, ror_v;

  assign shamt = b_i[SHAMT_W-1:0];
  assign lt_s  = $signed(a_i) < $signed(b_i);
  assign lt_u  = a_i < b_i;
  // Two's-complement negate; the most negative value maps to itself.
  assign neg_a = {XLEN{1'b0}} - a_i;

  // Rotate by zero is special-cased so the complementary shift never reaches XLEN.
  always_comb begin
    rol_v = a_i;
    ror_v = a_i;
    if (shamt != '0) begin
      rol_v = (a_i << shamt) | (a_i >> (XLEN - int'(shamt)));
      ror_v = (a_i >> shamt) | (a_i << (XLEN - int'(shamt)));
    end
  end

  always_comb begin
    y_o = '0;
    case (ctrl_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_AND:  y_o = a_i & b_i;
      ALU_OR:   y_o = a_i | b_i;
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_SLT:  y_o = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: y_o = {{(XLEN-1){1'b0}}, lt_u};
      ALU_SLL:  y_o = a_i << shamt;
      ALU_SRL:  y_o = a_i >> shamt;
      ALU_SRA:  y_o = $unsigned($signed(a_i) >>> shamt);
      ALU_ANDN: y_o = a_i & ~b_i;
      ALU_ORN:  y_o = a_i | ~b_i;
      ALU_XNOR: y_o = ~(a_i ^ b_i);
      ALU_MIN:  y_o = lt_s ? a_i : b_i;
      ALU_MAX:  y_o = lt_s ? b_i : a_i;
      ALU_MINU: y_o = lt_u ? a_i : b_i;
      ALU_MAXU: y_o = lt_u ? b_i : a_i;
      ALU_ROL:  y_o = rol_v;
      ALU_ROR:  y_o = ror_v;
      ALU_ABS:  y_o = a_i[XLEN-1] ? neg_a : a_i;
      default:  y_o = '0;
    endcase
  end
endmodule

// File: rtl/ex_stage.sv
// RVX10 execute stage: operand forwarding muxes, ALU, branch/jump redirect, EX/MEM register.
// Latency: EX/MEM outputs one cycle after capture; PCTargetE/PCSrcE combinational.
// Backpressure: EnM=0 holds EX/MEM; FlushM=1 loads a bubble and overrides EnM.
// Ports: clk, reset (async, active-high); bus = ex_stage_if slave (ID/EX in, EX/MEM + redirect out).
module ex_stage #(
  parameter int XLEN = 32
) (
  input logic        clk,
  input logic        reset,
  ex_stage_if.slave  bus
);
  import rvx10_pkg::*;

  logic [XLEN-1:0] src_a, write_data, src_b, alu_y, target_sum;
  logic            taken;

  // EX/MEM register state
  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] write_data_q, write_data_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic [4:0]      rd_q, rd_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_write_q, mem_write_d;
  logic [1:0]      result_src_q, result_src_d;

  // MEM forwarding taps the registered result, so a value computed this cycle never loops back.
  always_comb begin
    case (bus.ForwardA)
      FWD_MEM: src_a = alu_result_q;
      FWD_WB:  src_a = bus.ResultW;
      default: src_a = bus.RD1E;
    endcase
    case (bus.ForwardB)
      FWD_MEM: write_data = alu_result_q;
      FWD_WB:  write_data = bus.ResultW;
      default: write_data = bus.RD2E;
    endcase
  end

  assign src_b = bus.ALUSrcE ? bus.ImmExtE : write_data;

  alu #(.XLEN(XLEN)) u_alu (
    .a_i    (src_a),
    .b_i    (src_b),
    .ctrl_i (bus.ALUControlE),
    .y_o    (alu_y)
  );

  // Branches compare the forwarded rs2 value, not the immediate-muxed ALU operand.
  always_comb begin
    case (bus.Funct3E)
      BR_EQ:   taken = (src_a == write_data);
      BR_NE:   taken = (src_a != write_data);
      BR_LT:   taken = ($signed(src_a) <  $signed(write_data));
      BR_GE:   taken = ($signed(src_a) >= $signed(write_data));
      BR_LTU:  taken = (src_a <  write_data);
      BR_GEU:  taken = (src_a >= write_data);
      default: taken = 1'b0;
    endcase
  end

  assign target_sum    = (bus.JalrE ? src_a : bus.PCE) + bus.ImmExtE;
  assign bus.PCTargetE = bus.JalrE ? {target_sum[XLEN-1:1], 1'b0} : target_sum;
  assign bus.PCSrcE    = bus.JumpE | (bus.BranchE & taken);

  always_comb begin
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    pc_plus4_d   = pc_plus4_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mem_write_d  = mem_write_q;
    result_src_d = result_src_q;
    if (bus.FlushM) begin
      alu_result_d = '0;
      write_data_d = '0;
      pc_plus4_d   = '0;
      rd_d         = '0;
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
      result_src_d = '0;
    end else if (bus.EnM) begin
      alu_result_d = alu_y;
      write_data_d = write_data;
      pc_plus4_d   = bus.PCPlus4E;
      rd_d         = bus.RdE;
      reg_write_d  = bus.RegWriteE;
      mem_write_d  = bus.MemWriteE;
      result_src_d = bus.ResultSrcE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= '0;
    end else begin
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
    end
  end

  assign bus.ALUResultM = alu_result_q;
  assign bus.WriteDataM = write_data_q;
  assign bus.PCPlus4M   = pc_plus4_q;
  assign bus.RdM        = rd_q;
  assign bus.RegWriteM  = reg_write_q;
  assign bus.MemWriteM  = mem_write_q;
  assign bus.ResultSrcM = result_src_q;
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: random + directed ID/EX traffic against a word-level reference model.
// Latency: expects EX/MEM one cycle after each issued item; redirect checked same cycle.
// Backpressure: exercises EnM hold and FlushM bubbles, including FlushM over EnM.
module tb_ex_stage;
  import rvx10_pkg::*;

  typedef struct {
    logic [31:0] rd1, rd2, imm, pc, pc4, resw;
    logic [4:0]  rd, op;
    logic [2:0]  f3;
    logic [1:0]  rs, fa, fb;
    logic        alusrc, rw, mw, br, jmp, jalr, en, flush;
  } stim_t;

  typedef struct {
    logic [31:0] alu, wd, pc4;
    logic [4:0]  rd;
    logic        rw, mw;
    logic [1:0]  rs;
  } exp_t;

  logic clk, reset;
  int   tests, fails;
  exp_t m;           // model of the EX/MEM register contents
  exp_t sb[$];       // expected register contents after each clock edge

  ex_stage_if #(.XLEN(32)) bus();
  ex_stage #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int          sh;
    logic [63:0] dbl;
    sh  = int'(b[4:0]);
    dbl = {a, a};
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return a[31] ? ~((~a) >> sh) : (a >> sh);
      ALU_ANDN: return a & ~b;
      ALU_ORN:  return a | ~b;
      ALU_XNOR: return ~(a ^ b);
      ALU_MIN:  return (int'(a) < int'(b)) ? a : b;
      ALU_MAX:  return (int'(a) < int'(b)) ? b : a;
      ALU_MINU: return (a < b) ? a : b;
      ALU_MAXU: return (a < b) ? b : a;
      ALU_ROL:  begin dbl = dbl << sh; return dbl[63:32]; end
      ALU_ROR:  begin dbl = dbl >> sh; return dbl[31:0]; end
      ALU_ABS:  return (int'(a) < 0) ? (32'd0 - a) : a;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return int'(a) < int'(b);
      3'b101:  return int'(a) >= int'(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic stim_t mk();
    stim_t s;
    s = '{rd1: 0, rd2: 0, imm: 0, pc: 0, pc4: 0, resw: 0, rd: 0, op: 0, f3: 3'b010,
          rs: 0, fa: 0, fb: 0, alusrc: 0, rw: 0, mw: 0, br: 0, jmp: 0, jalr: 0,
          en: 1, flush: 0};
    return s;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input stim_t s);
    bus.RD1E = s.rd1;  bus.RD2E = s.rd2;  bus.ImmExtE = s.imm;
    bus.PCE = s.pc;    bus.PCPlus4E = s.pc4;  bus.ResultW = s.resw;
    bus.RdE = s.rd;    bus.Funct3E = s.f3;    bus.ALUControlE = s.op;
    bus.ALUSrcE = s.alusrc; bus.RegWriteE = s.rw; bus.MemWriteE = s.mw;
    bus.BranchE = s.br; bus.JumpE = s.jmp; bus.JalrE = s.jalr;
    bus.ResultSrcE = s.rs; bus.ForwardA = s.fa; bus.ForwardB = s.fb;
    bus.EnM = s.en; bus.FlushM = s.flush;
  endtask

  // Drive one item, check the redirect, and queue what EX/MEM must hold after the next edge.
  task automatic apply(input stim_t s);
    logic [31:0] a, wd, b, tgt;
    logic        psrc;
    exp_t        nxt;
    drive(s);
    #1;
    a    = (s.fa == 2'b01) ? m.alu : (s.fa == 2'b10) ? s.resw : s.rd1;
    wd   = (s.fb == 2'b01) ? m.alu : (s.fb == 2'b10) ? s.resw : s.rd2;
    b    = s.alusrc ? s.imm : wd;
    tgt  = s.jalr ? ((a + s.imm) & 32'hFFFF_FFFE) : (s.pc + s.imm);
    psrc = s.jmp | (s.br & ref_taken(s.f3, a, wd));
    chk("PCTargetE", bus.PCTargetE, tgt);
    chk("PCSrcE", 32'(bus.PCSrcE), 32'(psrc));
    if (reset || s.flush) nxt = '{alu: 0, wd: 0, pc4: 0, rd: 0, rw: 0, mw: 0, rs: 0};
    else if (s.en)        nxt = '{alu: ref_alu(s.op, a, b), wd: wd, pc4: s.pc4, rd: s.rd,
                                  rw: s.rw, mw: s.mw, rs: s.rs};
    else                  nxt = m;
    m = nxt;
    sb.push_back(nxt);
  endtask

  task automatic step(input stim_t s);
    @(negedge clk);
    apply(s);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ALUResultM"}, bus.ALUResultM, 0);
    chk({tag, "_WriteDataM"}, bus.WriteDataM, 0);
    chk({tag, "_PCPlus4M"}, bus.PCPlus4M, 0);
    chk({tag, "_RdM"}, 32'(bus.RdM), 0);
    chk({tag, "_RegWriteM"}, 32'(bus.RegWriteM), 0);
    chk({tag, "_MemWriteM"}, 32'(bus.MemWriteM), 0);
    chk({tag, "_ResultSrcM"}, 32'(bus.ResultSrcM), 0);
  endtask

  // Monitor: after every rising edge, compare EX/MEM against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("mon_ALUResultM", bus.ALUResultM, e.alu);
        chk("mon_WriteDataM", bus.WriteDataM, e.wd);
        chk("mon_PCPlus4M", bus.PCPlus4M, e.pc4);
        chk("mon_RdM", 32'(bus.RdM), 32'(e.rd));
        chk("mon_RegWriteM", 32'(bus.RegWriteM), 32'(e.rw));
        chk("mon_MemWriteM", 32'(bus.MemWriteM), 32'(e.mw));
        chk("mon_ResultSrcM", 32'(bus.ResultSrcM), 32'(e.rs));
      end
    end
  end

  initial begin
    stim_t s;
    tests = 0;
    fails = 0;
    m = '{alu: 0, wd: 0, pc4: 0, rd: 0, rw: 0, mw: 0, rs: 0};
    reset = 1'b1;
    drive(mk());
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // ADD 5 + 7
    s = mk(); s.op = ALU_ADD; s.rd1 = 5; s.rd2 = 7; s.rd = 3; s.rw = 1;
    step(s);
    @(posedge clk); #2;
    chk("add_ALUResultM", bus.ALUResultM, 32'd12);
    chk("add_WriteDataM", bus.WriteDataM, 32'd7);

    // Seed ALUResultM = 0x10, then SUB with MEM forward on A and WB forward on B
    s = mk(); s.op = ALU_ADD; s.rd1 = 32'h10;
    step(s);
    s = mk(); s.op = ALU_SUB; s.fa = 2'b01; s.fb = 2'b10; s.resw = 3;
    s.rd1 = 32'hDEAD_BEEF; s.rd2 = 32'h1234_5678;
    step(s);
    @(posedge clk); #2;
    chk("fwd_sub_ALUResultM", bus.ALUResultM, 32'hD);

    // RVX10 corner cases
    s = mk(); s.op = ALU_ROR; s.rd1 = 1; s.alusrc = 1; s.imm = 1;
    step(s);
    @(posedge clk); #2;
    chk("ror_1", bus.ALUResultM, 32'h8000_0000);
    s = mk(); s.op = ALU_ROL; s.rd1 = 32'hA5A5_0001; s.alusrc = 1; s.imm = 32'h20;
    step(s);
    @(posedge clk); #2;
    chk("rol_0", bus.ALUResultM, 32'hA5A5_0001);
    s = mk(); s.op = ALU_MIN; s.rd1 = 32'hFFFF_FFFF; s.rd2 = 1;
    step(s);
    @(posedge clk); #2;
    chk("min_signed", bus.ALUResultM, 32'hFFFF_FFFF);
    s.op = ALU_MINU;
    step(s);
    @(posedge clk); #2;
    chk("minu", bus.ALUResultM, 32'h1);
    s = mk(); s.op = ALU_ABS; s.rd1 = 32'h8000_0000;
    step(s);
    @(posedge clk); #2;
    chk("abs_min", bus.ALUResultM, 32'h8000_0000);
    s = mk(); s.op = 5'd25; s.rd1 = 32'h1234; s.rd2 = 32'h5678;
    step(s);
    @(posedge clk); #2;
    chk("undef_op", bus.ALUResultM, 32'h0);

    // BLTU 1 < 0xFFFFFFFF taken, then JALR target with bit0 cleared
    s = mk(); s.br = 1; s.f3 = 3'b110; s.rd1 = 1; s.rd2 = 32'hFFFF_FFFF; s.pc = 32'h100; s.imm = 32'h20;
    step(s);
    chk("bltu_PCSrcE", 32'(bus.PCSrcE), 32'd1);
    chk("bltu_PCTargetE", bus.PCTargetE, 32'h120);
    s = mk(); s.jalr = 1; s.jmp = 1; s.rd1 = 32'h203; s.imm = 0; s.pc = 32'h400;
    step(s);
    chk("jalr_PCTargetE", bus.PCTargetE, 32'h202);
    chk("jalr_PCSrcE", 32'(bus.PCSrcE), 32'd1);

    // Flush beats enable, then a hold cycle keeps the bubble
    s = mk(); s.flush = 1; s.rw = 1; s.mw = 1; s.rd = 7; s.rd1 = 9; s.rs = 2;
    step(s);
    @(posedge clk); #2;
    chk("flush_RegWriteM", 32'(bus.RegWriteM), 0);
    chk("flush_MemWriteM", 32'(bus.MemWriteM), 0);
    chk("flush_RdM", 32'(bus.RdM), 0);
    s = mk(); s.en = 0; s.rw = 1; s.mw = 1; s.rd = 12; s.rd1 = 44;
    step(s);
    @(posedge clk); #2;
    chk("hold_RegWriteM", 32'(bus.RegWriteM), 0);
    chk("hold_RdM", 32'(bus.RdM), 0);

    // Async reset between edges while RegWriteM=1
    s = mk(); s.rw = 1; s.mw = 1; s.rd = 9; s.rd1 = 32'h55; s.pc4 = 32'h44; s.rs = 1;
    step(s);
    @(posedge clk); #2;
    chk("pre_reset_RegWriteM", 32'(bus.RegWriteM), 1);
    #1 reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    m = '{alu: 0, wd: 0, pc4: 0, rd: 0, rw: 0, mw: 0, rs: 0};
    sb.delete();
    s = mk(); s.rw = 1; s.rd = 5; s.rd1 = 77; s.br = 1; s.f3 = 3'b000; s.pc = 32'h40; s.imm = 8;
    step(s);   // redirect still live in reset; register must stay clear
    @(negedge clk);
    reset = 1'b0;
    s = mk(); s.rw = 1; s.rd = 21; s.rd1 = 100; s.rd2 = 23; s.op = ALU_ADD; s.pc4 = 32'h88;
    apply(s);
    @(posedge clk); #2;
    chk("first_capture_RdM", 32'(bus.RdM), 32'd21);
    chk("first_capture_ALUResultM", bus.ALUResultM, 32'd123);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      s = mk();
      s.rd1 = pick(); s.rd2 = pick(); s.imm = pick(); s.resw = pick();
      s.pc = $urandom; s.pc4 = $urandom;
      s.rd = 5'($urandom_range(0, 31)); s.op = 5'($urandom_range(0, 31));
      s.f3 = 3'($urandom_range(0, 7)); s.rs = 2'($urandom_range(0, 3));
      s.fa = 2'($urandom_range(0, 3)); s.fb = 2'($urandom_range(0, 3));
      s.alusrc = 1'($urandom_range(0, 1)); s.rw = 1'($urandom_range(0, 1));
      s.mw = 1'($urandom_range(0, 1)); s.br = 1'($urandom_range(0, 1));
      s.jmp = ($urandom_range(0, 3) == 0); s.jalr = 1'($urandom_range(0, 1));
      s.en = ($urandom_range(0, 3) != 0); s.flush = ($urandom_range(0, 7) == 0);
      step(s);
    end

    @(posedge clk); #3;
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports RD1E, RD2E, ImmExtE, PCE, PCPlus4E  input  XLEN  ID/EX operands, immediate, PC, PC+4.
REQ-005 SHALL have ports RdE  input  5  destination register; Funct3E  input  3  branch condition.
REQ-006 SHALL have ports ALUControlE  input  5  ALU op; ALUSrcE, RegWriteE, MemWriteE, BranchE, JumpE, JalrE  input  1 each  controls.
REQ-007 SHALL have port ResultSrcE  input  2  writeback select, passed through.
REQ-008 SHALL have ports ForwardA, ForwardB  input  2  operand select from the forwarding unit.
REQ-009 SHALL have port ResultW  input  XLEN  writeback-stage result.
REQ-010 SHALL have ports EnM  input  1  EX/MEM capture enable; FlushM  input  1  insert bubble.
REQ-011 SHALL have ports ALUResultM, WriteDataM, PCPlus4M  output  XLEN  registered EX/MEM data.
REQ-012 SHALL have ports RdM  output  5; RegWriteM, MemWriteM  output  1; ResultSrcM  output  2  registered controls.
REQ-013 SHALL have ports PCTargetE  output  XLEN; PCSrcE  output  1  combinational redirect to fetch.

Function
REQ-014 SrcAE SHALL be RD1E for ForwardA=00, ALUResultM for 01, ResultW for 10, RD1E for 11; ForwardB SHALL select WriteDataE identically from RD2E.
REQ-015 SrcBE SHALL be ImmExtE when ALUSrcE=1, else WriteDataE.
REQ-016 ALU SHALL implement ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA and RVX10 ops ANDN, ORN, XNOR, MIN, MAX, MINU, MAXU, ROL, ROR, ABS; undefined codes SHALL yield 0.
REQ-017 Shift/rotate amount SHALL be SrcBE[4:0]; ROL/ROR by 0 SHALL return SrcAE; ABS of 0x80000000 SHALL return 0x80000000; all results wrap modulo 2^XLEN.
REQ-018 Branch compare SHALL use SrcAE vs WriteDataE: Funct3E 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; other codes not taken.
REQ-019 PCTargetE SHALL be (SrcAE+ImmExtE) with bit0 cleared when JalrE=1, else PCE+ImmExtE.
REQ-020 PCSrcE SHALL be JumpE OR (BranchE AND taken), combinational, same cycle.
REQ-021 On clk rise with FlushM=1, EX/MEM SHALL load RegWriteM=0, MemWriteM=0, RdM=0, ResultSrcM=00, data fields 0; FlushM SHALL override EnM.
REQ-022 On clk rise with FlushM=0, EnM=1, EX/MEM SHALL capture ALU result, WriteDataE, PCPlus4E, RdE and controls (latency one cycle).
REQ-023 With FlushM=0, EnM=0, all EX/MEM outputs SHALL hold.
REQ-024 ForwardA=01 SHALL use the currently registered ALUResultM, never the value being computed this cycle.

Reset
REQ-025 reset assertion SHALL immediately clear every registered output to 0, independent of clk.
REQ-026 Reset mid-operation SHALL discard in-flight EX/MEM contents; first capture SHALL occur on the first clk rise after deassertion.
REQ-027 PCTargetE/PCSrcE SHALL stay combinational during reset.

Structure
REQ-028 ALUControl encodings, Funct3 branch codes and Forward select codes SHALL live in shared package rvx10_pkg.
REQ-029 ALU SHALL be a separate sub-module named alu; muxes, branch logic and EX/MEM register stay in ex_stage.

Verification
REQ-030 ADD RD1E=5, RD2E=7, ForwardA=ForwardB=00, EnM=1 -> next cycle ALUResultM=12, WriteDataM=7.
REQ-031 ForwardA=01 with ALUResultM=0x10, ForwardB=10 with ResultW=0x3, SUB -> next ALUResultM=0xD.
REQ-032 ROR SrcA=0x00000001 by 1 -> 0x80000000; MIN 0xFFFFFFFF vs 1 -> 0xFFFFFFFF; MINU -> 1; ABS 0x80000000 -> 0x80000000.
REQ-033 BranchE=1, Funct3E=110, SrcA=1, WriteDataE=0xFFFFFFFF, PCE=0x100, Imm=0x20 -> PCSrcE=1, PCTargetE=0x120; JalrE with SrcA=0x203, Imm=0 -> 0x202.
REQ-034 FlushM=1 with EnM=1 -> RegWriteM=0, MemWriteM=0, RdM=0; next EnM=0 cycle holds those values.
REQ-035 Assert reset between clk edges with RegWriteM=1 -> all registered outputs 0 before next edge.
